hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 38 +++
 rtl/hazard_unit_fwd_sel.sv | 29 ++
 rtl/hazard_unit.sv | 163 ++++++++++++++++
 tb/tb_hazard_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: forwarding-select encoding,
// controller state codes and the bundled stall/flush vector.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef logic [0:0] state_t;

  localparam state_t ST_RUN      = 1'b0;
  localparam state_t ST_MEM_WAIT = 1'b1;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE     = 7'b000_0000;
  localparam hz_ctrl_t CTRL_MEM_WAIT = 7'b111_1001;
  localparam hz_ctrl_t CTRL_BRANCH   = 7'b000_0110;
  localparam hz_ctrl_t CTRL_LOAD_USE = 7'b110_0010;

  // Counter width that can hold the timeout threshold, never below 8 bits.
  function automatic int wait_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Operand forwarding comparator for one execute-stage source register.
// The M stage holds the younger result, so it wins over W.
module fwd_sel
  import hazard_unit_pkg::*;
(
  input  logic [4:0] rs_addr,
  input  logic [4:0] rd_m,
  input  logic       reg_wr_m,
  input  logic [4:0] rd_w,
  input  logic       reg_wr_w,
  output fwd_sel_e   sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_wr_m && (rd_m != 5'd0) && (rd_m == rs_addr);
  assign hit_w = reg_wr_w && (rd_w != 5'd0) && (rd_w == rs_addr);

  always_comb begin
    sel = FWD_RF;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use / branch / memory-wait
// stall and flush control, memory-wait timeout and statistics counters.
//
// state       | meaning
// ST_RUN      | normal issue; a stalled request cycle is covered combinationally
// ST_MEM_WAIT | data memory request outstanding, whole pipe held
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rs1_addr_E,
  input  logic [4:0]       rs2_addr_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             mem_rd_E,
  input  logic             reg_wr_M,
  input  logic             reg_wr_W,
  input  logic             br_taken_E,
  input  logic             dmem_req_M,
  input  logic             dmem_ready_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W      = wait_width(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  fwd_sel u_fwd_a (
    .rs_addr  (rs1_addr_E),
    .rd_m     (rd_M),
    .reg_wr_m (reg_wr_M),
    .rd_w     (rd_W),
    .reg_wr_w (reg_wr_W),
    .sel      (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_addr  (rs2_addr_E),
    .rd_m     (rd_M),
    .reg_wr_m (reg_wr_M),
    .rd_w     (rd_W),
    .reg_wr_w (reg_wr_W),
    .sel      (fwd_b)
  );

  assign fwd_a_E = fwd_a;
  assign fwd_b_E = fwd_b;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              load_use;
  logic              mem_done;
  logic              mem_wait;
  logic              still_waiting;
  logic [WAIT_W-1:0] wait_inc;
  hz_ctrl_t          ctrl;

  assign load_use = mem_rd_E && (rd_E != 5'd0) &&
                    ((rd_E == rs1_addr_D) || (rd_E == rs2_addr_D));

  // A ready strobe only counts while a request is actually presented.
  assign mem_done      = dmem_req_M && dmem_ready_M;
  assign mem_wait      = (state_q == ST_MEM_WAIT) || (dmem_req_M && !dmem_ready_M);
  assign still_waiting = (state_q == ST_MEM_WAIT) && !mem_done;
  assign wait_inc      = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

  // Reset forces the hold/bubble outputs low even though they are combinational.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!reset_n) begin
      ctrl = CTRL_IDLE;
    end else if (mem_wait) begin
      ctrl = CTRL_MEM_WAIT;
    end else if (br_taken_E) begin
      ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end
  end

  assign stall_F = ctrl.stall_f;
  assign stall_D = ctrl.stall_d;
  assign stall_E = ctrl.stall_e;
  assign stall_M = ctrl.stall_m;
  assign flush_D = ctrl.flush_d;
  assign flush_E = ctrl.flush_e;
  assign flush_W = ctrl.flush_w;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (dmem_req_M && !dmem_ready_M) begin
        state_d = ST_MEM_WAIT;
      end
    end else begin
      if (mem_done) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (still_waiting) begin
      wait_cnt_d = wait_inc;
      if (wait_inc == TIMEOUT_VAL) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(ctrl.stall_f);
    flush_cnt_d = flush_cnt_q + CNT_W'(ctrl.flush_d | ctrl.flush_e);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a behavioural model checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_hazard_unit;

  localparam int MT = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    rs1_addr_D = '0, rs2_addr_D = '0, rs1_addr_E = '0, rs2_addr_E = '0;
  logic [4:0]    rd_E = '0, rd_M = '0, rd_W = '0;
  logic          mem_rd_E = 0, reg_wr_M = 0, reg_wr_W = 0, br_taken_E = 0;
  logic          dmem_req_M = 0, dmem_ready_M = 0;
  logic          stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
  logic [1:0]    fwd_a_E, fwd_b_E;
  logic          mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .mem_rd_E(mem_rd_E), .reg_wr_M(reg_wr_M), .reg_wr_W(reg_wr_W),
    .br_taken_E(br_taken_E), .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  wire [6:0] ctrl_act = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state: whether a request is outstanding, how long it
  // has been outstanding, the sticky timeout and running event totals.
  bit m_waiting = 0;
  int m_wait    = 0;
  bit m_to      = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (reg_wr_M && rd_M != 0 && rd_M == rs) return 2'b10;
    if (reg_wr_W && rd_W != 0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] m_ctrl();
    bit memw, lu;
    memw = m_waiting || (dmem_req_M && !dmem_ready_M);
    lu   = mem_rd_E && rd_E != 0 && (rd_E == rs1_addr_D || rd_E == rs2_addr_D);
    if (!reset_n) return 7'b000_0000;
    if (memw)     return 7'b111_1001;
    if (br_taken_E) return 7'b000_0110;
    if (lu)       return 7'b110_0010;
    return 7'b000_0000;
  endfunction

  initial begin : compare
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_waiting = 0; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
      end
      e = m_ctrl();
      chk("ctrl", ctrl_act, e);
      chk("fwd_a", fwd_a_E, m_fwd(rs1_addr_E));
      chk("fwd_b", fwd_b_E, m_fwd(rs2_addr_E));
      chk("mem_timeout", mem_timeout, m_to);
      chk("stall_cnt", stall_cnt, 32'(m_stall % (1 << CW)));
      chk("flush_cnt", flush_cnt, 32'(m_flush % (1 << CW)));
      if (reset_n) begin
        m_stall += e[6];
        m_flush += (e[2] | e[1]);
        if (m_waiting) begin
          if (dmem_req_M && dmem_ready_M) begin
            m_waiting = 0;
            m_wait    = 0;
          end else begin
            m_wait++;
            if (m_wait >= MT) m_to = 1;
          end
        end else if (dmem_req_M && !dmem_ready_M) begin
          m_waiting = 1;
          m_wait    = 0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_addr_D = 0; rs2_addr_D = 0; rs1_addr_E = 0; rs2_addr_E = 0;
    rd_E = 0; rd_M = 0; rd_W = 0;
    mem_rd_E = 0; reg_wr_M = 0; reg_wr_W = 0; br_taken_E = 0;
    dmem_req_M = 0; dmem_ready_M = 0;
  endtask

  initial begin : stim
    // Reset state with inputs that would otherwise stall and flush.
    dmem_req_M = 1; br_taken_E = 1; mem_rd_E = 1; rd_E = 3; rs1_addr_D = 3;
    #2;
    chk("rst_ctrl", ctrl_act, 7'd0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_timeout", mem_timeout, 0);
    next_cycle();
    clear_inputs();
    next_cycle();
    reset_n = 1;

    // Forwarding priority and the x0 exclusion.
    rd_M = 5; reg_wr_M = 1; rd_W = 5; reg_wr_W = 1; rs1_addr_E = 5; rs2_addr_E = 5;
    #1 chk("fwd_m_prio", fwd_a_E, 2'b10);
    rd_M = 0;
    #1 chk("fwd_w_when_rd_m_zero", fwd_a_E, 2'b01);
    chk("fwd_b_w", fwd_b_E, 2'b01);
    next_cycle();
    clear_inputs();

    // Load-use: x7 loaded in E, consumed as rs2 in D.
    mem_rd_E = 1; rd_E = 7; rs2_addr_D = 7;
    @(negedge clk) chk("load_use_ctrl", ctrl_act, 7'b110_0010);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("load_use_one_cycle", ctrl_act, 7'd0);
    chk("load_use_stall_cnt", stall_cnt, 1);
    chk("load_use_flush_cnt", flush_cnt, 1);

    // Taken branch overrides the same load-use.
    next_cycle();
    mem_rd_E = 1; rd_E = 7; rs2_addr_D = 7; br_taken_E = 1;
    @(negedge clk) chk("branch_ctrl", ctrl_act, 7'b000_0110);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("branch_stall_cnt", stall_cnt, 1);
    chk("branch_flush_cnt", flush_cnt, 2);

    // Memory request with ready low for three cycles, then ready.
    next_cycle();
    dmem_req_M = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) chk("mem_wait_ctrl", ctrl_act, 7'b111_1001);
      next_cycle();
    end
    dmem_ready_M = 1;
    @(negedge clk) chk("mem_ready_cycle_ctrl", ctrl_act, 7'b111_1001);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("mem_back_to_run", ctrl_act, 7'd0);
    chk("mem_stall_cnt", stall_cnt, 5);
    chk("mem_flush_cnt", flush_cnt, 2);
    chk("mem_no_timeout", mem_timeout, 0);

    // Long wait trips the timeout, which then stays set.
    next_cycle();
    dmem_req_M = 1;
    repeat (6) next_cycle();
    dmem_ready_M = 1;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("timeout_set", mem_timeout, 1);
    chk("timeout_stall_cnt", stall_cnt, 12);
    repeat (3) next_cycle();
    chk("timeout_sticky", mem_timeout, 1);

    // Reset asserted mid-wait, between clock edges.
    dmem_req_M = 1;
    next_cycle();
    next_cycle();
    #2 reset_n = 0;
    #1;
    chk("async_rst_ctrl", ctrl_act, 7'd0);
    chk("async_rst_timeout", mem_timeout, 0);
    chk("async_rst_stall_cnt", stall_cnt, 0);
    chk("async_rst_flush_cnt", flush_cnt, 0);
    dmem_req_M = 0;
    next_cycle();
    next_cycle();
    reset_n = 1;
    @(negedge clk) chk("post_rst_run", ctrl_act, 7'd0);

    // Random traffic; occasional resets, counters allowed to wrap.
    for (int i = 0; i < 5000; i++) begin
      next_cycle();
      rs1_addr_D   = 5'($urandom_range(0, 7));
      rs2_addr_D   = 5'($urandom_range(0, 7));
      rs1_addr_E   = 5'($urandom_range(0, 7));
      rs2_addr_E   = 5'($urandom_range(0, 7));
      rd_E         = 5'($urandom_range(0, 7));
      rd_M         = 5'($urandom_range(0, 7));
      rd_W         = 5'($urandom_range(0, 7));
      mem_rd_E     = 1'($urandom_range(0, 1));
      reg_wr_M     = 1'($urandom_range(0, 1));
      reg_wr_W     = 1'($urandom_range(0, 1));
      br_taken_E   = ($urandom_range(0, 4) == 0);
      dmem_req_M   = ($urandom_range(0, 2) == 0);
      dmem_ready_M = 1'($urandom_range(0, 1));
      reset_n      = ($urandom_range(0, 1499) != 0);
    end

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
